// File: rtl/full_adder_bit.sv
// One-bit full adder cell; the ripple-carry leaf chained by full_adder_reg.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic prop;

  assign prop  = x ^ y;
  assign s     = prop ^ c_in;
  assign c_out = (x & y) | (c_in & prop);

endmodule

// File: rtl/full_adder_reg.sv
// Ripple-carry adder with combinational sum/carry/overflow plus a registered copy.
// The combinational outputs ignore clk/rst; only the registered copy is reset.
module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic [WIDTH-1:0] s_q,
  output logic             c_out_q,
  output logic             ovf_q,
  output logic             out_valid
);

  logic [WIDTH:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .x     (x[i]),
      .y     (y[i]),
      .c_in  (carry[i]),
      .s     (s[i]),
      .c_out (carry[i+1])
    );
  end

  assign c_out = carry[WIDTH];
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf   = carry[WIDTH-1] ^ carry[WIDTH];

  logic [WIDTH-1:0] sum_q,  sum_d;
  logic             cout_q, cout_d;
  logic             ovfl_q, ovfl_d;
  logic             valid_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    sum_d  = sum_q;
    cout_d = cout_q;
    ovfl_d = ovfl_q;
    if (in_valid) begin
      sum_d  = s;
      cout_d = c_out;
      ovfl_d = ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
      valid_q <= in_valid;
    end
  end

  assign s_q       = sum_q;
  assign c_out_q   = cout_q;
  assign ovf_q     = ovfl_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed bench for full_adder_reg at WIDTH=1 and WIDTH=8 with hand-computed expectations.
module tb_full_adder_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       x1, y1, cin1;
  logic [7:0] x8, y8;
  logic       cin8;

  logic       s1, cout1, ovf1, sq1, coutq1, ovfq1, vld1;
  logic [7:0] s8, sq8;
  logic       cout8, ovf8, coutq8, ovfq8, vld8;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  full_adder_reg #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .c_in(cin1), .in_valid(in_valid),
    .s(s1), .c_out(cout1), .ovf(ovf1),
    .s_q(sq1), .c_out_q(coutq1), .ovf_q(ovfq1), .out_valid(vld1)
  );

  full_adder_reg #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .x(x8), .y(y8), .c_in(cin8), .in_valid(in_valid),
    .s(s8), .c_out(cout8), .ovf(ovf8),
    .s_q(sq8), .c_out_q(coutq8), .ovf_q(ovfq8), .out_valid(vld8)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truth table as {c_out, s}, indexed by {x, y, c_in}.
  logic [1:0] tt_exp [8];

  initial begin
    tt_exp[0] = 2'b00; tt_exp[1] = 2'b01; tt_exp[2] = 2'b01; tt_exp[3] = 2'b10;
    tt_exp[4] = 2'b01; tt_exp[5] = 2'b10; tt_exp[6] = 2'b10; tt_exp[7] = 2'b11;

    rst = 1'b0; in_valid = 1'b0;
    x1 = 1'b0; y1 = 1'b0; cin1 = 1'b0;
    x8 = 8'h00; y8 = 8'h00; cin8 = 1'b0;

    // Reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_sq1",   {8'h0, sq1},    9'h0);
    check("rst_coutq1",{8'h0, coutq1}, 9'h0);
    check("rst_vld1",  {8'h0, vld1},   9'h0);
    check("rst_sq8",   {1'b0, sq8},    9'h0);

    // Combinational truth table, no dependence on clock or reset
    for (int i = 0; i < 8; i++) begin
      {x1, y1, cin1} = 3'(i);
      #10;
      check($sformatf("tt_%0d", i), {7'h0, cout1, s1}, {7'h0, tt_exp[i]});
      check($sformatf("tt_ovf_%0d", i), {8'h0, ovf1}, {8'h0, tt_exp[i][1] ^ cin1});
    end

    @(negedge clk) rst = 1'b0;

    // Load s_q=1, then async reset between edges
    @(negedge clk) begin x1 = 1'b1; y1 = 1'b0; cin1 = 1'b0; in_valid = 1'b1; end
    @(posedge clk) #1;
    check("load_sq1",  {8'h0, sq1},  9'h1);
    check("load_vld1", {8'h0, vld1}, 9'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_sq1",    {8'h0, sq1},    9'h0);
    check("arst_coutq1", {8'h0, coutq1}, 9'h0);
    check("arst_ovfq1",  {8'h0, ovfq1},  9'h0);
    check("arst_vld1",   {8'h0, vld1},   9'h0);
    check("arst_s1",     {8'h0, s1},     9'h1);

    // Reset held across an edge with in_valid=1 discards the capture
    @(posedge clk) #1;
    check("rstwin_sq1", {8'h0, sq1},  9'h0);
    check("rstwin_vld", {8'h0, vld1}, 9'h0);
    @(negedge clk) begin rst = 1'b0; in_valid = 1'b0; end

    // Register path: capture 1+1+1, then hold with in_valid=0
    @(negedge clk) begin x1 = 1'b1; y1 = 1'b1; cin1 = 1'b1; in_valid = 1'b1; end
    @(posedge clk) #1;
    check("reg_sq1",    {8'h0, sq1},    9'h1);
    check("reg_coutq1", {8'h0, coutq1}, 9'h1);
    check("reg_ovfq1",  {8'h0, ovfq1},  9'h0);
    check("reg_vld1",   {8'h0, vld1},   9'h1);
    @(negedge clk) begin x1 = 1'b0; y1 = 1'b0; cin1 = 1'b0; in_valid = 1'b0; end
    @(posedge clk) #1;
    check("hold_sq1",    {8'h0, sq1},    9'h1);
    check("hold_coutq1", {8'h0, coutq1}, 9'h1);
    check("hold_vld1",   {8'h0, vld1},   9'h0);

    // WIDTH=8 combinational cases
    x8 = 8'hFF; y8 = 8'h01; cin8 = 1'b0; #1;
    check("w8_wrap",     {cout8, s8}, 9'h100);
    check("w8_wrap_ovf", {8'h0, ovf8}, 9'h0);
    x8 = 8'hFF; y8 = 8'hFF; cin8 = 1'b1; #1;
    check("w8_max",      {cout8, s8}, 9'h1FF);
    check("w8_max_ovf",  {8'h0, ovf8}, 9'h0);
    x8 = ~8'd3; y8 = 8'd5; cin8 = 1'b1; #1;
    check("w8_sub",      {cout8, s8}, 9'h102);
    x8 = 8'h7F; y8 = 8'h01; cin8 = 1'b0; #1;
    check("w8_sovf",     {cout8, s8}, 9'h080);
    check("w8_sovf_ovf", {8'h0, ovf8}, 9'h1);

    // WIDTH=8 register capture of the overflow case
    @(negedge clk) in_valid = 1'b1;
    @(posedge clk) #1;
    check("w8_reg_sq",   {coutq8, sq8}, 9'h080);
    check("w8_reg_ovfq", {8'h0, ovfq8}, 9'h1);
    check("w8_reg_vld",  {8'h0, vld8},  9'h1);
    @(negedge clk) in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
